scobra_input_cond: RTL and testbench
====================================

# scobra_input_cond

Input conditioning stage for the Super Cobra AX309 build. It sits between the raw J2-header joystick/button pins and the AX309 push buttons on one side, and the `SCOBRA_TOP` player, coin and start inputs on the other. It provides:
- two-flop synchronisation and per-channel debounce;
- a fixed-length coin pulse with holdoff;
- the exact bit packing and polarity `SCOBRA_TOP` expects on `ip_1p`, `ip_2p` and `ip_coin1`.

## Interface
Parameters:
- `TICK_DIV`, 24576: `clk` cycles per debounce tick (1 kHz at 24.576 MHz).
- `DB_TICKS`, 10: consecutive stable ticks required to accept a new level.
- `COIN_TICKS`, 100: coin pulse length in ticks.
- `HOLD_TICKS`, 200: coin holdoff after pulse, in ticks.
- `AF_TICKS`, 50: autofire half-period in ticks (used only with `SCOBRA_AUTOFIRE_EN`).

Ports:
- `clk` in 1: 24.576 MHz system clock; the only clock.
- `BTN_nRESET` in 1: reset, synchronous, active-low.
- `sw_raw` in 6: raw joystick/buttons, active-high, asynchronous. Bit order is {BOMB, FIRE, LEFT, RIGHT, UP, DOWN}, bit 5 first.
- `key_raw` in 3: AX309 keys, async. Bit 0 is coin, bit 1 is 1P start, bit 2 is 2P start.
- `ip_1p` out 7: {start1, ~BOMB, ~FIRE, ~LEFT, ~RIGHT, ~UP, ~DOWN}, debounced.
- `ip_2p` out 7: {start2, same six inverted bits}.
- `ip_coin1` out 1: active-high coin pulse.

## Operation
- **Synchroniser:** each of the 9 raw inputs passes through 2 flops.
- **Tick prescaler:**
  - Counter from 0 to `TICK_DIV`-1, width clog2(`TICK_DIV`).
  - `tick` is a one-cycle strobe when the counter equals `TICK_DIV`-1; the counter then wraps to 0.
- **Debounce, per channel:**
  - State is a stable level `db` plus a counter of width clog2(`DB_TICKS`+1).
  - If the synced input equals `db`, the counter clears on every cycle.
  - Otherwise, on each `tick` the counter increments. When it reaches `DB_TICKS`, `db` takes the synced value and the counter clears.
  - Any return to `db` before that point clears the counter, so glitches are fully rejected.
- **Coin FSM:** runs on debounced coin `cdb` and its registered copy `cdb_q`.
  - IDLE: on a rising edge (`cdb` & ~`cdb_q`), go to PULSE and load the timer with `COIN_TICKS`.
  - PULSE: `ip_coin1`=1. Timer decrements on `tick`. At 0, go to HOLD and load `HOLD_TICKS`.
  - HOLD: `ip_coin1`=0. Timer decrements on `tick`. At 0, if `cdb`=0 go to IDLE; otherwise stay in HOLD (wait for release).
  - Edges arriving during PULSE or HOLD are ignored, not queued.
  - The timer is shared, with width clog2(max(`COIN_TICKS`, `HOLD_TICKS`)+1).
- **Output packing:**
  - Joystick bits are the inverted debounced values.
  - Start bits are debounced and not inverted.
  - The same six joystick bits drive both `ip_1p` and `ip_2p`.
- **Reset:**
  - All flops clear.
  - `db`=0 on every channel, so `ip_1p`/`ip_2p` read 7'b0111111.
  - `ip_coin1`=0; FSM in IDLE; prescaler is 0.
  - Reset asserted mid-pulse drops `ip_coin1` on the next edge.
  - After reset releases, an already-held coin key produces a pulse once debounced: `db` starts at 0, so acceptance is a rising edge.

## Timing
- All outputs are registered.
- Press-to-output latency is 2 sync cycles plus `DB_TICKS` ticks plus at most one partial tick, i.e. between (`DB_TICKS`-1)·`TICK_DIV` and `DB_TICKS`·`TICK_DIV` cycles, plus 3 cycles.
- The coin pulse asserts 1 cycle after `cdb` rises.
- The coin pulse lasts between `COIN_TICKS`-1 and `COIN_TICKS` tick periods, since the first decrement is on the next `tick`.
- The minimum coin-to-coin spacing is `COIN_TICKS`+`HOLD_TICKS` ticks.
- If a `tick` coincides with an input change, the change is evaluated first: a mismatch increments, a match clears.

## Configuration
- `SCOBRA_AUTOFIRE_EN` **defined:**
  - While debounced FIRE=1, the FIRE output toggles every `AF_TICKS` ticks.
  - It starts in the pressed state on acceptance.
  - It returns to released immediately when debounced FIRE=0.
  - The phase counter resets on release.
- **Undefined:** FIRE passes straight through from debounce, and `AF_TICKS` is unused.

## Structure
- Package `scobra_input_pkg`:
  - Index constants `IDX_DOWN`=0 … `IDX_BOMB`=5 and `KEY_COIN`/`KEY_START1`/`KEY_START2`.
  - Coin FSM state enum {`C_IDLE`, `C_PULSE`, `C_HOLD`}.
- Sub-module `scobra_debounce`:
  - One channel holding the synchroniser, `db` and counter, and taking the shared `tick`.
  - Instantiated 9 times via generate.

## Test plan
Bench parameters: `TICK_DIV`=4, `DB_TICKS`=3, `COIN_TICKS`=2, `HOLD_TICKS`=3, `AF_TICKS`=2.
1. **Reset values:** hold `BTN_nRESET`=0 with all raw inputs 1 → `ip_1p`=`ip_2p`=7'b0111111 and `ip_coin1`=0. Release → values unchanged until debounce completes.
2. **Glitch rejection:** `sw_raw[4]` (FIRE) high for 6 cycles, then low → `ip_1p[4]` stays 1.
3. **Accepted press:** FIRE held high → `ip_1p[4]` and `ip_2p[4]` fall between 11 and 15 cycles after the raw edge; other bits unchanged.
4. **Coin pulse:** `key_raw[0]` held for 200 cycles → exactly one `ip_coin1` pulse of 5–8 cycles. A second press inside HOLD produces no pulse; a press after release and holdoff produces a second pulse.
5. **Reset mid-pulse:** assert `BTN_nRESET`=0 while `ip_coin1`=1 → `ip_coin1`=0 on the next edge and FSM in IDLE.
6. **Autofire:** FIRE held for 100 cycles, with `SCOBRA_AUTOFIRE_EN` defined → `ip_1p[4]` toggles every 8 cycles after acceptance. Undefined → it stays 0.

Source files
------------

// File: rtl/scobra_input_pkg.sv
// Shared constants and types for the Super Cobra input conditioning stage.
package scobra_input_pkg;

    localparam int unsigned IDX_DOWN  = 0;
    localparam int unsigned IDX_UP    = 1;
    localparam int unsigned IDX_RIGHT = 2;
    localparam int unsigned IDX_LEFT  = 3;
    localparam int unsigned IDX_FIRE  = 4;
    localparam int unsigned IDX_BOMB  = 5;

    localparam int unsigned KEY_COIN   = 0;
    localparam int unsigned KEY_START1 = 1;
    localparam int unsigned KEY_START2 = 2;

    localparam int unsigned NUM_SW  = 6;
    localparam int unsigned NUM_KEY = 3;

    typedef enum logic [1:0] {
        C_IDLE,
        C_PULSE,
        C_HOLD
    } coin_state_t;

endpackage

// File: rtl/scobra_debounce.sv
// One input channel: two-flop synchroniser plus tick-based debounce.
module scobra_debounce #(
    parameter int unsigned DB_TICKS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic db
);

    localparam int unsigned CW = $clog2(DB_TICKS + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // A match always wins, so a tick landing on a glitch's end still clears.
            if (s2 == db) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CW'(DB_TICKS - 1)) begin
                    db  <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scobra_input_cond.sv
// Joystick/key conditioning for SCOBRA_TOP: sync, debounce, coin pulse, bit packing.
// Optional autofire on FIRE is enabled by defining SCOBRA_AUTOFIRE_EN.
module scobra_input_cond
    import scobra_input_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 24576,
    parameter int unsigned DB_TICKS   = 10,
    parameter int unsigned COIN_TICKS = 100,
    parameter int unsigned HOLD_TICKS = 200,
    parameter int unsigned AF_TICKS   = 50
) (
    input  logic       clk,
    input  logic       BTN_nRESET,
    input  logic [5:0] sw_raw,
    input  logic [2:0] key_raw,
    output logic [6:0] ip_1p,
    output logic [6:0] ip_2p,
    output logic       ip_coin1
);

    localparam int unsigned PW   = $clog2(TICK_DIV);
    localparam int unsigned TMAX = (COIN_TICKS > HOLD_TICKS) ? COIN_TICKS : HOLD_TICKS;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    logic [PW-1:0]  pre_cnt;
    logic           tick;
    logic [8:0]     raw_all;
    logic [8:0]     db_all;
    logic [5:0]     sw_db;
    logic [2:0]     key_db;
    logic           cdb;
    logic           cdb_q;
    logic           fire_eff;
    logic [5:0]     joy;
    coin_state_t    coin_state;
    logic [TW-1:0]  timer;

    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!BTN_nRESET) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign raw_all = {key_raw, sw_raw};

    for (genvar i = 0; i < NUM_SW + NUM_KEY; i++) begin : g_ch
        scobra_debounce #(
            .DB_TICKS (DB_TICKS)
        ) u_db (
            .clk   (clk),
            .rst_n (BTN_nRESET),
            .tick  (tick),
            .raw   (raw_all[i]),
            .db    (db_all[i])
        );
    end

    assign sw_db  = db_all[5:0];
    assign key_db = db_all[8:6];
    assign cdb    = key_db[KEY_COIN];

`ifdef SCOBRA_AUTOFIRE_EN
    localparam int unsigned AW = $clog2(AF_TICKS + 1);

    logic [AW-1:0] af_cnt;
    logic          af_on;

    // Phase restarts in the pressed state whenever FIRE is released.
    always_ff @(posedge clk) begin
        if (!BTN_nRESET || !sw_db[IDX_FIRE]) begin
            af_cnt <= '0;
            af_on  <= 1'b1;
        end else if (tick) begin
            if (af_cnt == AW'(AF_TICKS - 1)) begin
                af_cnt <= '0;
                af_on  <= ~af_on;
            end else begin
                af_cnt <= af_cnt + 1'b1;
            end
        end
    end

    assign fire_eff = sw_db[IDX_FIRE] & af_on;
`else
    logic unused_af;
    assign unused_af = ^AF_TICKS;
    assign fire_eff  = sw_db[IDX_FIRE];
`endif

    always_comb begin
        joy           = ~sw_db;
        joy[IDX_FIRE] = ~fire_eff;
    end

    always_ff @(posedge clk) begin
        if (!BTN_nRESET) begin
            ip_1p <= 7'b0111111;
            ip_2p <= 7'b0111111;
        end else begin
            ip_1p <= {key_db[KEY_START1], joy};
            ip_2p <= {key_db[KEY_START2], joy};
        end
    end

    always_ff @(posedge clk) begin
        if (!BTN_nRESET) begin
            coin_state <= C_IDLE;
            timer      <= '0;
            ip_coin1   <= 1'b0;
            cdb_q      <= 1'b0;
        end else begin
            cdb_q <= cdb;
            unique case (coin_state)
                C_IDLE: begin
                    if (cdb && !cdb_q) begin
                        coin_state <= C_PULSE;
                        timer      <= TW'(COIN_TICKS);
                        ip_coin1   <= 1'b1;
                    end
                end
                C_PULSE: begin
                    if (tick) begin
                        if (timer <= TW'(1)) begin
                            coin_state <= C_HOLD;
                            timer      <= TW'(HOLD_TICKS);
                            ip_coin1   <= 1'b0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                C_HOLD: begin
                    // Holdoff expired: leave only once the key is seen released.
                    if (timer == '0) begin
                        if (!cdb) begin
                            coin_state <= C_IDLE;
                        end
                    end else if (tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    coin_state <= C_IDLE;
                    ip_coin1   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scobra_input_cond.sv
// Directed bench for scobra_input_cond with small timing parameters.
module tb_scobra_input_cond;
    import scobra_input_pkg::*;

    logic       clk = 1'b0;
    logic       BTN_nRESET;
    logic [5:0] sw_raw;
    logic [2:0] key_raw;
    logic [6:0] ip_1p;
    logic [6:0] ip_2p;
    logic       ip_coin1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    scobra_input_cond #(
        .TICK_DIV   (4),
        .DB_TICKS   (3),
        .COIN_TICKS (2),
        .HOLD_TICKS (3),
        .AF_TICKS   (2)
    ) dut (
        .clk        (clk),
        .BTN_nRESET (BTN_nRESET),
        .sw_raw     (sw_raw),
        .key_raw    (key_raw),
        .ip_1p      (ip_1p),
        .ip_2p      (ip_2p),
        .ip_coin1   (ip_coin1)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        BTN_nRESET = 1'b0;
        sw_raw     = '1;
        key_raw    = '1;
        step(3);
        vectors++;
        if ({ip_1p, ip_2p, ip_coin1} !== {7'b0111111, 7'b0111111, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold: got 1p=%b 2p=%b coin=%b want 0111111 0111111 0",
                     ip_1p, ip_2p, ip_coin1);
        end
        BTN_nRESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            vectors++;
            if ({ip_1p, ip_2p, ip_coin1} !== {7'b0111111, 7'b0111111, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_release cyc %0d: got 1p=%b 2p=%b coin=%b want unchanged",
                         i, ip_1p, ip_2p, ip_coin1);
            end
        end
        step(15);
        vectors++;
        if ({ip_1p, ip_2p} !== {7'b1000000, 7'b1000000}) begin
            miscompares++;
            $display("FAIL all_pressed: got 1p=%b 2p=%b want 1000000 1000000", ip_1p, ip_2p);
        end
        sw_raw  = '0;
        key_raw = '0;
        step(40);
        vectors++;
        if ({ip_1p, ip_2p, ip_coin1} !== {7'b0111111, 7'b0111111, 1'b0}) begin
            miscompares++;
            $display("FAIL all_released: got 1p=%b 2p=%b coin=%b want 0111111 0111111 0",
                     ip_1p, ip_2p, ip_coin1);
        end
    endtask

    task automatic test_glitch;
        sw_raw[IDX_FIRE] = 1'b1;
        step(6);
        sw_raw[IDX_FIRE] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(1);
            vectors++;
            if (ip_1p !== 7'b0111111) begin
                miscompares++;
                $display("FAIL glitch cyc %0d: got 1p=%b want 0111111", i, ip_1p);
            end
        end
    endtask

    task automatic test_press;
        int lat;
        lat = 0;
        sw_raw[IDX_FIRE] = 1'b1;
        while (ip_1p[IDX_FIRE] !== 1'b0 && lat < 40) begin
            step(1);
            lat++;
        end
        vectors++;
        if (lat < 11 || lat > 15) begin
            miscompares++;
            $display("FAIL press_latency: got %0d cycles want 11..15", lat);
        end
        vectors++;
        if ({ip_1p, ip_2p} !== {7'b0101111, 7'b0101111}) begin
            miscompares++;
            $display("FAIL press_value: got 1p=%b 2p=%b want 0101111 0101111", ip_1p, ip_2p);
        end
        sw_raw[IDX_FIRE] = 1'b0;
        step(30);
        vectors++;
        if ({ip_1p, ip_2p} !== {7'b0111111, 7'b0111111}) begin
            miscompares++;
            $display("FAIL press_release: got 1p=%b 2p=%b want 0111111 0111111", ip_1p, ip_2p);
        end
    endtask

    task automatic test_start;
        key_raw[KEY_START2] = 1'b1;
        sw_raw[IDX_DOWN]    = 1'b1;
        step(20);
        vectors++;
        if ({ip_1p, ip_2p} !== {7'b0111110, 7'b1111110}) begin
            miscompares++;
            $display("FAIL start2_down: got 1p=%b 2p=%b want 0111110 1111110", ip_1p, ip_2p);
        end
        key_raw[KEY_START2] = 1'b0;
        key_raw[KEY_START1] = 1'b1;
        sw_raw[IDX_DOWN]    = 1'b0;
        sw_raw[IDX_BOMB]    = 1'b1;
        step(20);
        vectors++;
        if ({ip_1p, ip_2p} !== {7'b1011111, 7'b0011111}) begin
            miscompares++;
            $display("FAIL start1_bomb: got 1p=%b 2p=%b want 1011111 0011111", ip_1p, ip_2p);
        end
        key_raw = '0;
        sw_raw  = '0;
        step(25);
    endtask

    task automatic test_coin;
        int seg_len [6] = '{100, 4, 96, 40, 40, 40};
        bit seg_lvl [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int pulses;
        int first_pulses;
        int width;
        logic prev;
        pulses = 0;
        first_pulses = 0;
        width = 0;
        prev = ip_coin1;
        for (int s = 0; s < 6; s++) begin
            key_raw[KEY_COIN] = seg_lvl[s];
            for (int i = 0; i < seg_len[s]; i++) begin
                step(1);
                if (ip_coin1 === 1'b1) begin
                    if (prev !== 1'b1) pulses++;
                    width++;
                end else if (prev === 1'b1) begin
                    vectors++;
                    if (width < 5 || width > 8) begin
                        miscompares++;
                        $display("FAIL coin_width pulse %0d: got %0d cycles want 5..8",
                                 pulses, width);
                    end
                    width = 0;
                end
                prev = ip_coin1;
            end
            if (s == 3) first_pulses = pulses;
        end
        vectors++;
        if (first_pulses != 1) begin
            miscompares++;
            $display("FAIL coin_single: got %0d pulses want 1", first_pulses);
        end
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("FAIL coin_second: got %0d pulses want 2", pulses);
        end
    endtask

    task automatic test_reset_mid_pulse;
        int n;
        n = 0;
        key_raw[KEY_COIN] = 1'b1;
        while (ip_coin1 !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        vectors++;
        if (ip_coin1 !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pulse_start: got coin=%b want 1 within 40 cycles", ip_coin1);
        end
        BTN_nRESET = 1'b0;
        step(1);
        vectors++;
        if (ip_coin1 !== 1'b0 || dut.coin_state !== C_IDLE) begin
            miscompares++;
            $display("FAIL mid_pulse_reset: got coin=%b state=%0d want 0 %0d",
                     ip_coin1, dut.coin_state, C_IDLE);
        end
        step(2);
        BTN_nRESET = 1'b1;
        n = 0;
        while (ip_coin1 !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        vectors++;
        if (ip_coin1 !== 1'b1) begin
            miscompares++;
            $display("FAIL held_coin_after_reset: got coin=%b want 1 within 40 cycles", ip_coin1);
        end
        key_raw[KEY_COIN] = 1'b0;
        step(50);
    endtask

    task automatic test_autofire;
        int n;
        n = 0;
        sw_raw[IDX_FIRE] = 1'b1;
        while (ip_1p[IDX_FIRE] !== 1'b0 && n < 20) begin
            step(1);
            n++;
        end
        vectors++;
        if (ip_1p[IDX_FIRE] !== 1'b0) begin
            miscompares++;
            $display("FAIL af_accept: got fire=%b want 0 within 20 cycles", ip_1p[IDX_FIRE]);
        end
`ifdef SCOBRA_AUTOFIRE_EN
        begin
            logic last;
            int since;
            int toggles;
            last = 1'b0;
            since = 0;
            toggles = 0;
            for (int i = 0; i < 85; i++) begin
                step(1);
                since++;
                if (ip_1p[IDX_FIRE] !== last) begin
                    toggles++;
                    vectors++;
                    if (since != 8) begin
                        miscompares++;
                        $display("FAIL af_period toggle %0d: got %0d cycles want 8",
                                 toggles, since);
                    end
                    last = ip_1p[IDX_FIRE];
                    since = 0;
                end
            end
            vectors++;
            if (toggles < 9) begin
                miscompares++;
                $display("FAIL af_toggles: got %0d want >= 9", toggles);
            end
        end
`else
        for (int i = 0; i < 85; i++) begin
            step(1);
            vectors++;
            if (ip_1p[IDX_FIRE] !== 1'b0) begin
                miscompares++;
                $display("FAIL af_off cyc %0d: got fire=%b want 0", i, ip_1p[IDX_FIRE]);
            end
        end
`endif
        sw_raw[IDX_FIRE] = 1'b0;
        step(30);
        vectors++;
        if (ip_1p !== 7'b0111111) begin
            miscompares++;
            $display("FAIL af_release: got 1p=%b want 0111111", ip_1p);
        end
    endtask

    initial begin
        BTN_nRESET = 1'b0;
        sw_raw     = '0;
        key_raw    = '0;
        test_reset();
        test_glitch();
        test_press();
        test_start();
        test_coin();
        test_reset_mid_pulse();
        test_autofire();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
